// File: rtl/eddy_current_sensor_spi_rx_if.sv
// SPI and sample-output bundle of the eddy current sensor capture front end.
// master = capture block, slave = ADC/register-block side.
interface eddy_current_sensor_spi_rx_if;
    logic        cnv;
    logic        sclk;
    logic        miso_x;
    logic        miso_y;
    logic [31:0] data_x;
    logic [31:0] data_y;
    logic        data_valid;

    modport master (
        output cnv, sclk, data_x, data_y, data_valid,
        input  miso_x, miso_y
    );

    modport slave (
        input  cnv, sclk, data_x, data_y, data_valid,
        output miso_x, miso_y
    );
endinterface

// File: rtl/eddy_current_sensor_spi_rx.sv
// Dual-channel eddy current ADC capture: CNV pulse, then parallel SPI shift-in.
// ECS_SIGN_EXTEND_EN: sign-extend samples to 32 bits (else zero-extend).
module eddy_current_sensor_spi_rx #(
    parameter int DATA_WIDTH  = 18,
    parameter int SCLK_DIV    = 5,
    parameter int CONV_CYCLES = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic trigger,
    input  logic clear_missed,
    output logic busy,
    output logic trigger_missed,
    eddy_current_sensor_spi_rx_if.master bus
);

    localparam int CMAX = (CONV_CYCLES > SCLK_DIV) ? CONV_CYCLES : SCLK_DIV;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] sh_x;
    logic [DATA_WIDTH-1:0] sh_y;
    logic [DATA_WIDTH-1:0] nx;
    logic [DATA_WIDTH-1:0] ny;

    function automatic logic [31:0] ext(input logic [DATA_WIDTH-1:0] s);
        logic [31:0] w;
        w = 32'(s);
`ifdef ECS_SIGN_EXTEND_EN
        for (int i = DATA_WIDTH; i < 32; i++) w[i] = s[DATA_WIDTH-1];
`endif
        return w;
    endfunction

    // Shift register contents including the bit being sampled this cycle
    assign nx = {sh_x[DATA_WIDTH-2:0], bus.miso_x};
    assign ny = {sh_y[DATA_WIDTH-2:0], bus.miso_y};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            sh_x           <= '0;
            sh_y           <= '0;
            bus.cnv        <= 1'b0;
            bus.sclk       <= 1'b0;
            bus.data_x     <= '0;
            bus.data_y     <= '0;
            bus.data_valid <= 1'b0;
            busy           <= 1'b0;
            trigger_missed <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            if (trigger && state != IDLE)
                trigger_missed <= 1'b1;
            else if (clear_missed)
                trigger_missed <= 1'b0;

            case (state)
                IDLE: begin
                    if (trigger && enable) begin
                        state   <= CONV;
                        cnv_hi: bus.cnv <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                    end
                end
                CONV: begin
                    if (cnt == CW'(CONV_CYCLES - 1)) begin
                        state   <= SHIFT;
                        bus.cnv <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SHIFT: begin
                    if (cnt == CW'(SCLK_DIV - 1)) begin
                        cnt <= '0;
                        if (!bus.sclk) begin
                            bus.sclk <= 1'b1;
                        end else begin
                            // Last high cycle of the bit: sample, then fall
                            bus.sclk <= 1'b0;
                            sh_x     <= nx;
                            sh_y     <= ny;
                            bit_cnt  <= bit_cnt + BW'(1);
                            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                                state          <= DONE;
                                bus.data_x     <= ext(nx);
                                bus.data_y     <= ext(ny);
                                bus.data_valid <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
